// File: rtl/evm_pkg.sv
// Shared EVM definitions: candidate count, vote input conditioner FSM states,
// controller state encodings and a one-hot helper.
package evm_pkg;

    localparam int unsigned NUM_CANDIDATES = 3;

    // Vote input conditioner arbitration states
    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        OUT    = 2'd1,
        LOCKED = 2'd2
    } cond_state_t;

    // EVM controller state encodings, shared with the controller
    typedef enum logic [1:0] {
        CTRL_IDLE     = 2'd0,
        CTRL_VOTER_IN = 2'd1,
        CTRL_VOTED    = 2'd2,
        CTRL_RESULT   = 2'd3
    } ctrl_state_t;

    // True when exactly one candidate bit is set
    function automatic logic is_one_hot(input logic [NUM_CANDIDATES-1:0] v);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < int'(NUM_CANDIDATES); i++) begin
            ones += int'(v[i]);
        end
        return (ones == 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: two-flop synchroniser, symmetric debounce counter
// and rising-edge detect on the debounced level.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   btn       : asynchronous raw button
//   level     : debounced level (registered)
//   rise      : one-cycle pulse in the cycle after level goes 0->1 (registered)
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // Level toggles after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            cnt       <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync      <= sync_meta;
            rise      <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= ~level;
                rise  <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vote_input_conditioner.sv
// Vote input conditioner: debounces the three vote buttons, arbitrates
// presses and emits a fixed-length one-hot vote while arm_en is high,
// then locks out until every button is released.
// Optional feature macro: REJECT_CNT_EN adds the reject_count port/counter.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   btn_raw[2:0]      : asynchronous buttons, bit 0 = candidate 1
//   arm_en            : voting window open
//   vote_candidate_N  : one-hot vote levels, PULSE_CYCLES long
//   multi_press       : one-cycle pulse when a press is rejected
//   reject_count[7:0] : saturating count of rejected presses (REJECT_CNT_EN)
module vote_input_conditioner
    import evm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_raw,
    input  logic       arm_en,
    output logic       vote_candidate_1,
    output logic       vote_candidate_2,
    output logic       vote_candidate_3,
    output logic       multi_press
`ifdef REJECT_CNT_EN
    ,
    output logic [7:0] reject_count
`endif
);

    localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);

    logic [NUM_CANDIDATES-1:0] level;
    logic [NUM_CANDIDATES-1:0] rise;

    cond_state_t               state;
    cond_state_t               state_next;
    logic [NUM_CANDIDATES-1:0] vote;
    logic [NUM_CANDIDATES-1:0] vote_next;
    logic [PW-1:0]             pulse_cnt;
    logic [PW-1:0]             pulse_cnt_next;
    logic                      multi;
    logic                      multi_next;

    // Per-button conditioning
    for (genvar i = 0; i < int'(NUM_CANDIDATES); i++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_raw[i]),
            .level(level[i]),
            .rise (rise[i])
        );
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARMED;
            vote      <= '0;
            pulse_cnt <= '0;
            multi     <= 1'b0;
        end else begin
            state     <= state_next;
            vote      <= vote_next;
            pulse_cnt <= pulse_cnt_next;
            multi     <= multi_next;
        end
    end

    // Arbitration: a fresh rise is needed; the full debounced vector decides
    // validity, so a rise while another button is held is also rejected.
    always_comb begin
        state_next     = state;
        vote_next      = vote;
        pulse_cnt_next = pulse_cnt;
        multi_next     = 1'b0;
        case (state)
            ARMED: begin
                vote_next = '0;
                if (arm_en && (rise != '0)) begin
                    if (is_one_hot(level)) begin
                        vote_next      = level;
                        pulse_cnt_next = PW'(PULSE_CYCLES);
                        state_next     = OUT;
                    end else begin
                        multi_next = 1'b1;
                        state_next = LOCKED;
                    end
                end
            end
            OUT: begin
                if (pulse_cnt <= PW'(1)) begin
                    vote_next      = '0;
                    pulse_cnt_next = '0;
                    state_next     = LOCKED;
                end else begin
                    pulse_cnt_next = pulse_cnt - PW'(1);
                end
            end
            LOCKED: begin
                vote_next = '0;
                if (level == '0) begin
                    state_next = ARMED;
                end
            end
            default: begin
                vote_next      = '0;
                pulse_cnt_next = '0;
                state_next     = ARMED;
            end
        endcase
    end

`ifdef REJECT_CNT_EN
    // Saturating reject counter, bumped on the same edge multi_press rises
    always_ff @(posedge clk) begin
        if (rst) begin
            reject_count <= 8'd0;
        end else if (multi_next && (reject_count != 8'hFF)) begin
            reject_count <= reject_count + 8'd1;
        end
    end
`endif

    assign vote_candidate_1 = vote[0];
    assign vote_candidate_2 = vote[1];
    assign vote_candidate_3 = vote[2];
    assign multi_press      = multi;

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Directed bench for vote_input_conditioner with DEBOUNCE_CYCLES=4,
// PULSE_CYCLES=2. Inputs change 1 ns after a rising edge; outputs are
// sampled at the same point, so "tick k" means "after edge k".
module tb_vote_input_conditioner;

    logic       clk;
    logic       rst;
    logic [2:0] btn_raw;
    logic       arm_en;
    logic       vote_candidate_1;
    logic       vote_candidate_2;
    logic       vote_candidate_3;
    logic       multi_press;
`ifdef REJECT_CNT_EN
    logic [7:0] reject_count;
`endif

    int unsigned n_cmp;
    int unsigned n_err;
    logic        seen_vote;
    logic        seen_multi;

    wire [2:0] votes = {vote_candidate_3, vote_candidate_2, vote_candidate_1};

    vote_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES   (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .btn_raw         (btn_raw),
        .arm_en          (arm_en),
        .vote_candidate_1(vote_candidate_1),
        .vote_candidate_2(vote_candidate_2),
        .vote_candidate_3(vote_candidate_3),
        .multi_press     (multi_press)
`ifdef REJECT_CNT_EN
        ,
        .reject_count    (reject_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance n edges recording whether any vote or multi_press appeared
    task automatic watch(input int n);
        seen_vote  = 1'b0;
        seen_multi = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (votes != 3'b000) seen_vote = 1'b1;
            if (multi_press) seen_multi = 1'b1;
        end
    endtask

    // Press pattern, expect a clean vote after edge 7 lasting 2 cycles
    task automatic expect_vote(input string tag, input logic [2:0] pat);
        btn_raw = pat;
        watch(6);
        check({tag, "_early"}, {31'd0, seen_vote}, 32'd0);
        tick();
        check({tag, "_e7"}, {29'd0, votes}, {29'd0, pat});
        tick();
        check({tag, "_e8"}, {29'd0, votes}, {29'd0, pat});
        tick();
        check({tag, "_e9"}, {29'd0, votes}, 32'd0);
    endtask

    task automatic release_all();
        btn_raw = 3'b000;
        ticks(10);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        btn_raw = 3'b000;
        arm_en  = 1'b0;
        ticks(3);
        check("reset_votes", {29'd0, votes}, 32'd0);
        check("reset_multi", {31'd0, multi_press}, 32'd0);
`ifdef REJECT_CNT_EN
        check("reset_rejects", {24'd0, reject_count}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Clean press, then hold: single vote only
        arm_en = 1'b1;
        expect_vote("clean", 3'b001);
        watch(20);
        check("clean_hold_novote", {31'd0, seen_vote}, 32'd0);
        release_all();

        // Bounce on candidate 2, final stable rise is edge 1
        btn_raw = 3'b010; tick();
        btn_raw = 3'b000; tick();
        btn_raw = 3'b010; tick();
        btn_raw = 3'b000; tick();
        expect_vote("bounce", 3'b010);
        release_all();

        // Simultaneous press is rejected
        btn_raw = 3'b011;
        watch(6);
        check("multi_early", {30'd0, seen_vote, seen_multi}, 32'd0);
        tick();
        check("multi_pulse", {31'd0, multi_press}, 32'd1);
        check("multi_novote", {29'd0, votes}, 32'd0);
`ifdef REJECT_CNT_EN
        check("multi_rejects", {24'd0, reject_count}, 32'd1);
`endif
        watch(8);
        check("multi_after", {30'd0, seen_vote, seen_multi}, 32'd0);
        release_all();
        expect_vote("after_multi", 3'b100);
        release_all();

        // Held through window opening: no vote
        arm_en  = 1'b0;
        btn_raw = 3'b001;
        watch(12);
        check("window_closed", {30'd0, seen_vote, seen_multi}, 32'd0);
        arm_en = 1'b1;
        watch(12);
        check("window_held", {30'd0, seen_vote, seen_multi}, 32'd0);
        // Second button rising while first held is rejected
        btn_raw = 3'b011;
        watch(6);
        check("held_multi_early", {31'd0, seen_multi}, 32'd0);
        tick();
        check("held_multi_pulse", {31'd0, multi_press}, 32'd1);
        check("held_multi_novote", {29'd0, votes}, 32'd0);
`ifdef REJECT_CNT_EN
        check("held_multi_rejects", {24'd0, reject_count}, 32'd2);
`endif
        release_all();
        expect_vote("window_repress", 3'b001);
        release_all();

        // arm_en drop one cycle into OUT does not truncate the pulse
        btn_raw = 3'b010;
        ticks(7);
        check("armdrop_e7", {29'd0, votes}, 32'd2);
        arm_en = 1'b0;
        tick();
        check("armdrop_e8", {29'd0, votes}, 32'd2);
        tick();
        check("armdrop_e9", {29'd0, votes}, 32'd0);
        release_all();
        arm_en = 1'b1;

        // Reset during OUT clears outputs on the next edge
        btn_raw = 3'b001;
        ticks(7);
        check("rst_pre", {29'd0, votes}, 32'd1);
        rst     = 1'b1;
        btn_raw = 3'b000;
        tick();
        check("rst_votes", {29'd0, votes}, 32'd0);
        check("rst_multi", {31'd0, multi_press}, 32'd0);
        rst = 1'b0;
        ticks(10);

`ifdef REJECT_CNT_EN
        check("sat_restart", {24'd0, reject_count}, 32'd0);
        for (int i = 0; i < 254; i++) begin
            btn_raw = 3'b011; ticks(8);
            btn_raw = 3'b000; ticks(10);
        end
        check("sat_254", {24'd0, reject_count}, 32'd254);
        for (int i = 0; i < 6; i++) begin
            btn_raw = 3'b011; ticks(8);
            btn_raw = 3'b000; ticks(10);
        end
        check("sat_255", {24'd0, reject_count}, 32'd255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
